// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data_memory, with
// bounded locked bursts, address legality filtering and registered responses.
module dmem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int MAX_BURST   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_valid,
  input  logic                  p0_we,
  input  logic                  p0_lock,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ready,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_valid,
  input  logic                  p1_we,
  input  logic                  p1_lock,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ready,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int                    CNT_W      = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]      BURST_MAX  = CNT_W'(MAX_BURST);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DEPTH_WORDS * 4);

  logic             r_last_grant;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_lock_valid;
  logic             r_lock_port;

  logic                  w_any_valid;
  logic                  w_grant;
  logic                  w_win_port;
  logic                  w_sel_we;
  logic                  w_sel_lock;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_legal;
  logic                  w_p0_gnt;
  logic                  w_p1_gnt;

  assign w_any_valid = p0_valid | p1_valid;
  assign w_grant     = w_any_valid & rst_n;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_win_port = 1'b0;
    if (p0_valid && !p1_valid) begin
      w_win_port = 1'b0;
    end else if (!p0_valid && p1_valid) begin
      w_win_port = 1'b1;
    end else if (r_lock_valid && (r_burst_cnt < BURST_MAX)) begin
      w_win_port = r_lock_port;
    end else begin
      w_win_port = ~r_last_grant;
    end
  end

  assign w_sel_we    = w_win_port ? p1_we    : p0_we;
  assign w_sel_lock  = w_win_port ? p1_lock  : p0_lock;
  assign w_sel_addr  = w_win_port ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_win_port ? p1_wdata : p0_wdata;
  assign w_legal     = (w_sel_addr[1:0] == 2'b00) && (w_sel_addr < ADDR_LIMIT);

  assign w_p0_gnt = w_grant & ~w_win_port;
  assign w_p1_gnt = w_grant &  w_win_port;
  assign p0_ready = w_p0_gnt;
  assign p1_ready = w_p1_gnt;

  // Illegal addresses are still granted (to get an error response) but never strobe memory.
  assign mem_read  = w_grant & w_legal & ~w_sel_we;
  assign mem_write = w_grant & w_legal &  w_sel_we;
  assign mem_addr  = w_any_valid ? w_sel_addr  : '0;
  assign mem_wdata = w_any_valid ? w_sel_wdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_burst_cnt  <= '0;
      r_lock_valid <= 1'b0;
      r_lock_port  <= 1'b0;
      p0_rvalid    <= 1'b0;
      p0_rdata     <= '0;
      p0_err       <= 1'b0;
      p1_rvalid    <= 1'b0;
      p1_rdata     <= '0;
      p1_err       <= 1'b0;
    end else begin
      p0_rvalid <= w_p0_gnt;
      p0_err    <= w_p0_gnt & ~w_legal;
      p0_rdata  <= (w_p0_gnt && mem_read) ? mem_rdata : '0;
      p1_rvalid <= w_p1_gnt;
      p1_err    <= w_p1_gnt & ~w_legal;
      p1_rdata  <= (w_p1_gnt && mem_read) ? mem_rdata : '0;

      if (w_grant) begin
        r_last_grant <= w_win_port;
        if (w_sel_lock) begin
          r_lock_valid <= 1'b1;
          r_lock_port  <= w_win_port;
          // A lock carried over from a different port starts a fresh burst.
          if (r_lock_valid && (r_lock_port == w_win_port)) begin
            if (r_burst_cnt < BURST_MAX) begin
              r_burst_cnt <= r_burst_cnt + 1'b1;
            end
          end else begin
            r_burst_cnt <= CNT_W'(1);
          end
        end else begin
          r_lock_valid <= 1'b0;
          r_burst_cnt  <= '0;
        end
      end else begin
        r_lock_valid <= 1'b0;
        r_burst_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a behavioural data_memory and
// per-port response scoreboards.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_valid, p0_we, p0_lock, p0_ready, p0_rvalid, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_valid, p1_we, p1_lock, p1_ready, p1_rvalid, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(256), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ready(p0_ready), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ready(p1_ready), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Power-up memory contents: word k holds k * 0x00010003 until written.
  function automatic logic [31:0] init_word(input int k);
    return 32'(k) * 32'h0001_0003;
  endfunction

  logic [31:0]  tb_mem [0:255];
  logic [255:0] tb_wr = '0;
  logic [7:0]   w_idx;
  assign w_idx     = mem_addr[9:2];
  assign mem_rdata = tb_wr[w_idx] ? tb_mem[w_idx] : init_word(int'(w_idx));

  always @(posedge clk) begin
    if (mem_write) begin
      tb_mem[w_idx] <= mem_wdata;
      tb_wr[w_idx]  <= 1'b1;
    end
  end

  typedef struct {
    string       name;
    logic        rst;
    logic        v0, we0, lk0;
    logic [31:0] a0, d0;
    logic        v1, we1, lk1;
    logic [31:0] a1, d1;
    logic [1:0]  rdy;   // {p1_ready, p0_ready}
    logic [1:0]  mem;   // {mem_read, mem_write}
    logic [31:0] rd;    // response data of the granted access
    logic        err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        err;
  } resp_t;

  resp_t q0[$];
  resp_t q1[$];
  int    n_cmp = 0;
  int    n_mis = 0;
  int    rv_cnt0 = 0;
  int    rv_cnt1 = 0;

  function automatic vec_t mk(input string name, input logic rst,
                              input logic v0, we0, lk0, input logic [31:0] a0, d0,
                              input logic v1, we1, lk1, input logic [31:0] a1, d1,
                              input logic [1:0] rdy, mem,
                              input logic [31:0] rd, input logic err);
    vec_t v;
    v.name = name; v.rst = rst;
    v.v0 = v0; v.we0 = we0; v.lk0 = lk0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.lk1 = lk1; v.a1 = a1; v.d1 = d1;
    v.rdy = rdy; v.mem = mem; v.rd = rd; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_resp(input int port);
    resp_t       e;
    logic        has;
    logic        rv, er;
    logic [31:0] rd;
    if (port == 0) begin
      rv = p0_rvalid; rd = p0_rdata; er = p0_err;
      has = (q0.size() > 0);
      if (has) e = q0.pop_front();
      if (rv) rv_cnt0++;
    end else begin
      rv = p1_rvalid; rd = p1_rdata; er = p1_err;
      has = (q1.size() > 0);
      if (has) e = q1.pop_front();
      if (rv) rv_cnt1++;
    end
    check($sformatf("p%0d_rvalid", port), 32'(rv), 32'(has));
    if (has) begin
      check($sformatf("%s/p%0d_rdata", e.name, port), rd, e.rd);
      check($sformatf("%s/p%0d_err", e.name, port), 32'(er), 32'(e.err));
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic run_cycle(input vec_t v);
    resp_t r;
    rst_n    = ~v.rst;
    p0_valid = v.v0; p0_we = v.we0; p0_lock = v.lk0; p0_addr = v.a0; p0_wdata = v.d0;
    p1_valid = v.v1; p1_we = v.we1; p1_lock = v.lk1; p1_addr = v.a1; p1_wdata = v.d1;
    @(negedge clk);
    check({v.name, "/ready"}, 32'({p1_ready, p0_ready}), 32'(v.rdy));
    check({v.name, "/strobes"}, 32'({mem_read, mem_write}), 32'(v.mem));
    if (!v.v0 && !v.v1) begin
      check({v.name, "/idle_addr"}, mem_addr, 32'h0);
      check({v.name, "/idle_wdata"}, mem_wdata, 32'h0);
    end
    r.name = v.name; r.rd = v.rd; r.err = v.err;
    if (v.rdy[0]) q0.push_back(r);
    if (v.rdy[1]) q1.push_back(r);
    @(posedge clk);
    #1;
    check_resp(0);
    check_resp(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    int          n0, n1, base0, base1;
    logic        w;
    logic [31:0] a0, a1, erd;

    rst_n = 1'b0;
    p0_valid = 1'b0; p0_we = 1'b0; p0_lock = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_lock = 1'b0; p1_addr = '0; p1_wdata = '0;

    //         name          rst  v0 we0 lk0 a0          d0            v1 we1 lk1 a1          d1            rdy    mem    rd            err
    tbl.push_back(mk("t01_p0_rd0",   '0, '1,'0,'0, 32'h0,      32'h0,        '0,'0,'0, 32'h0,      32'h0,        2'b01, 2'b10, 32'h0,        '0));
    tbl.push_back(mk("t02_p1_rd4",   '0, '0,'0,'0, 32'h0,      32'h0,        '1,'0,'0, 32'h4,      32'h0,        2'b10, 2'b10, 32'h00010003, '0));
    tbl.push_back(mk("t03_wr_both",  '0, '1,'1,'0, 32'h8,      32'h11,       '1,'1,'0, 32'hC,      32'h22,       2'b01, 2'b01, 32'h0,        '0));
    tbl.push_back(mk("t04_p1_wr",    '0, '0,'0,'0, 32'h0,      32'h0,        '1,'1,'0, 32'hC,      32'h22,       2'b10, 2'b01, 32'h0,        '0));
    tbl.push_back(mk("t05_rd_both",  '0, '1,'0,'0, 32'h8,      32'h0,        '1,'0,'0, 32'hC,      32'h0,        2'b01, 2'b10, 32'h11,       '0));
    tbl.push_back(mk("t06_p1_rdC",   '0, '0,'0,'0, 32'h0,      32'h0,        '1,'0,'0, 32'hC,      32'h0,        2'b10, 2'b10, 32'h22,       '0));
    tbl.push_back(mk("t07_misalign", '0, '1,'0,'0, 32'h2,      32'h0,        '0,'0,'0, 32'h0,      32'h0,        2'b01, 2'b00, 32'h0,        '1));
    tbl.push_back(mk("t08_range",    '0, '1,'0,'0, 32'h400,    32'h0,        '0,'0,'0, 32'h0,      32'h0,        2'b01, 2'b00, 32'h0,        '1));
    tbl.push_back(mk("t09_p1_wmis",  '0, '0,'0,'0, 32'h0,      32'h0,        '1,'1,'0, 32'h6,      32'hBAD,      2'b10, 2'b00, 32'h0,        '1));
    tbl.push_back(mk("t10_p1_wrng",  '0, '0,'0,'0, 32'h0,      32'h0,        '1,'1,'0, 32'h404,    32'hBAD,      2'b10, 2'b00, 32'h0,        '1));
    tbl.push_back(mk("t11_rd_top",   '0, '1,'0,'0, 32'h3FC,    32'h0,        '0,'0,'0, 32'h0,      32'h0,        2'b01, 2'b10, 32'h00FF02FD, '0));
    tbl.push_back(mk("t12_idle",     '0, '0,'0,'0, 32'h0,      32'h0,        '0,'0,'0, 32'h0,      32'h0,        2'b00, 2'b00, 32'h0,        '0));
    tbl.push_back(mk("t13_wr_top",   '0, '1,'1,'0, 32'h3FC,    32'h5A5A0001, '0,'0,'0, 32'h0,      32'h0,        2'b01, 2'b01, 32'h0,        '0));
    tbl.push_back(mk("t14_rr_p1",    '0, '1,'0,'0, 32'h4,      32'h0,        '1,'0,'0, 32'h3FC,    32'h0,        2'b10, 2'b10, 32'h5A5A0001, '0));
    tbl.push_back(mk("t15_p0_rd4",   '0, '1,'0,'0, 32'h4,      32'h0,        '0,'0,'0, 32'h0,      32'h0,        2'b01, 2'b10, 32'h00010003, '0));
    tbl.push_back(mk("t16_p1_rd10",  '0, '0,'0,'0, 32'h0,      32'h0,        '1,'0,'0, 32'h10,     32'h0,        2'b10, 2'b10, 32'h0004000C, '0));

    repeat (2) @(posedge clk);
    #1;
    check("reset/p0_rvalid", 32'(p0_rvalid), 32'h0);
    check("reset/p1_rvalid", 32'(p1_rvalid), 32'h0);
    check("reset/p0_rdata", p0_rdata, 32'h0);
    check("reset/p1_rdata", p1_rdata, 32'h0);
    check("reset/p0_err", 32'(p0_err), 32'h0);
    check("reset/p1_err", 32'(p1_err), 32'h0);

    for (int i = 0; i < tbl.size(); i++) run_cycle(tbl[i]);

    // Both ports stream unlocked reads; the loser holds its address until granted.
    n0 = 0; n1 = 0;
    base0 = rv_cnt0; base1 = rv_cnt1;
    for (int i = 0; i < 8; i++) begin
      w   = (i % 2) == 1;
      a0  = 32'h40 + 32'(4 * n0);
      a1  = 32'h80 + 32'(4 * n1);
      erd = w ? init_word(32 + n1) : init_word(16 + n0);
      run_cycle(mk($sformatf("stream%0d", i), '0, '1, '0, '0, a0, 32'h0, '1, '0, '0, a1, 32'h0,
                   w ? 2'b10 : 2'b01, 2'b10, erd, '0));
      if (w) n1++;
      else n0++;
    end
    check("stream/p0_resps", 32'(rv_cnt0 - base0), 32'd4);
    check("stream/p1_resps", 32'(rv_cnt1 - base1), 32'd4);

    // p1 bursts under lock; after 4 grants p0 gets one slot, then p1 resumes.
    run_cycle(mk("lk1_p1",     '0, '0,'0,'0, 32'h0, 32'h0, '1,'0,'1, 32'h20, 32'h0, 2'b10, 2'b10, 32'h00080018, '0));
    run_cycle(mk("lk2_p1",     '0, '1,'0,'0, 32'h0, 32'h0, '1,'0,'1, 32'h24, 32'h0, 2'b10, 2'b10, 32'h0009001B, '0));
    run_cycle(mk("lk3_p1",     '0, '1,'0,'0, 32'h0, 32'h0, '1,'0,'1, 32'h28, 32'h0, 2'b10, 2'b10, 32'h000A001E, '0));
    run_cycle(mk("lk4_p1",     '0, '1,'0,'0, 32'h0, 32'h0, '1,'0,'1, 32'h2C, 32'h0, 2'b10, 2'b10, 32'h000B0021, '0));
    run_cycle(mk("lk5_p0",     '0, '1,'0,'0, 32'h0, 32'h0, '1,'0,'1, 32'h30, 32'h0, 2'b01, 2'b10, 32'h0,        '0));
    run_cycle(mk("lk6_p1",     '0, '0,'0,'0, 32'h0, 32'h0, '1,'0,'1, 32'h30, 32'h0, 2'b10, 2'b10, 32'h000C0024, '0));
    run_cycle(mk("lk7_p1",     '0, '0,'0,'0, 32'h0, 32'h0, '1,'0,'1, 32'h34, 32'h0, 2'b10, 2'b10, 32'h000D0027, '0));
    run_cycle(mk("lk8_idle",   '0, '0,'0,'0, 32'h0, 32'h0, '0,'0,'0, 32'h0,  32'h0, 2'b00, 2'b00, 32'h0,        '0));

    // Reset lands mid-burst with a p0 write presented: write dropped, lock cleared.
    run_cycle(mk("rs1_p1lock", '0, '0,'0,'0, 32'h0, 32'h0,        '1,'0,'1, 32'h38, 32'h0, 2'b10, 2'b10, 32'h000E002A, '0));
    run_cycle(mk("rs2_inrst",  '1, '1,'1,'0, 32'h4, 32'hDEADBEEF, '1,'0,'1, 32'h3C, 32'h0, 2'b00, 2'b00, 32'h0,        '0));
    run_cycle(mk("rs3_p0rd4",  '0, '1,'0,'0, 32'h4, 32'h0,        '1,'0,'1, 32'h3C, 32'h0, 2'b01, 2'b10, 32'h00010003, '0));
    run_cycle(mk("rs4_p1",     '0, '0,'0,'0, 32'h0, 32'h0,        '1,'0,'1, 32'h3C, 32'h0, 2'b10, 2'b10, 32'h000F002D, '0));
    run_cycle(mk("rs5_idle",   '0, '0,'0,'0, 32'h0, 32'h0,        '0,'0,'0, 32'h0,  32'h0, 2'b00, 2'b00, 32'h0,        '0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
